serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first N-bit adder with a start/done handshake.
- It is the additive counterpart of the existing subtractor cells: one full-adder slice and a carry flip-flop are reused across WIDTH clock cycles.
- It is the area-minimal arithmetic unit for the basic_circuits library and serves as the sequential reference for future serial subtract/compare blocks.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 2.

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      asynchronous, active-low reset
- start   input   1      request; sampled on rising clk edge, accepted only in IDLE
- a       input   WIDTH  operand A; captured when start is accepted
- b       input   WIDTH  operand B; captured when start is accepted
- cin     input   1      carry-in; captured when start is accepted
- busy    output  1      high while bits are being processed (RUN state)
- done    output  1      one-cycle pulse; sum/cout/ovf valid and updated
- sum     output  WIDTH  result a+b+cin mod 2^WIDTH; holds until the next result
- cout    output  1      carry-out of the MSB
- ovf     output  1      signed overflow flag (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset (rst_n=0, takes effect immediately, regardless of clk):
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - internal shift registers, carry and bit counter = 0
- All outputs are registered; nothing is combinational from inputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch a, b into shift registers and cin into the carry FF.
  - Clear the bit counter and go to RUN (busy=1 from that edge).
  - With start=0, remain in IDLE.
- RUN, one bit per edge:
  - s = a_sh[0]^b_sh[0]^c
  - c <= majority(a_sh[0], b_sh[0], c)
  - s shifts into the MSB of the result shift register; a_sh and b_sh shift right; counter increments.
  - On the WIDTH-th RUN edge, sum, cout and ovf load from the completed result and final carry, done<=1, busy<=0, and the state goes to DONE.
- DONE: lasts exactly one cycle; done<=0 on the next edge and the state returns to IDLE.
- Latency:
  - start accepted at edge E0 → done high after edge E_WIDTH.
  - Next start is accepted no earlier than edge E_WIDTH+2 (one cycle in DONE, then IDLE).
  - Throughput: one operation per WIDTH+2 cycles.
- sum/cout/ovf are never updated mid-operation; they show the previous result during RUN.
- start while busy=1 or done=1 is ignored. It has no effect on operands, result or timing, and is not queued.
- a, b and cin may change freely after acceptance.
- rst_n asserted mid-RUN aborts the operation: the reset values apply immediately, and a subsequent start behaves as from power-up.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry-out.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - An extra FF records the carry into the MSB slice during the last RUN cycle.
  - ovf = carry_into_MSB ^ cout, loaded with sum on the done edge.
  - ovf is cleared by reset and holds like sum.
- Undefined:
  - The extra FF is not built.
  - ovf is tied to 0 and the port is still present.

Test Plan:
- Reset: hold rst_n=0, toggle clk → busy=0, done=0, sum=8'h00, cout=0, ovf=0; release rst_n, idle 3 cycles → outputs unchanged.
- Basic add, WIDTH=8:
  - a=8'h35, b=8'h4A, cin=0, 1-cycle start pulse → busy high for 8 cycles.
  - done high for exactly 1 cycle, 8 edges after the start edge.
  - sum=8'h7F, cout=0.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
  - Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
  - Back-to-back starts are accepted at E0 and E10.
- Start during busy:
  - Accept a=8'h10, b=8'h20; hold start=1 with a=8'hAA, b=8'h55 for the whole RUN+DONE.
  - → first done gives sum=8'h30.
  - Second operation starts only in IDLE and gives sum=8'hFF.
- Reset mid-operation:
  - Start a=8'h0F, b=8'h01; assert rst_n=0 between edges 4 and 5 → busy, done, sum drop to 0 without waiting for clk.
  - Release and restart same operands → sum=8'h10, cout=0.
- Overflow, run with and without SERIAL_ADDER_OVF_EN:
  - a=8'h7F, b=8'h01 → sum=8'h80, cout=0; ovf=1 (defined) / 0 (undefined).
  - a=8'h80, b=8'h80 → sum=8'h00, cout=1; ovf=1 / 0.
  - a=8'hFF, b=8'h01 → ovf=0 in both builds.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry FF, reused over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // start is accepted only in IDLE; done is a one-cycle pulse in DONE.
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] r_next;

    assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign r_next = {s_bit, r_sh[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= r_next;
                        cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the last bit, carry is the carry into the MSB slice.
                        ovf_q <= carry ^ c_next;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Expected result entries: {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] prev;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        int unsigned total;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        total = int'(x) + int'(y) + int'(ci);
        s  = total[W-1:0];
        co = total[W];
`ifdef SERIAL_ADDER_OVF_EN
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`else
        ov = 1'b0;
`endif
        return {ov, co, s};
    endfunction

    task automatic check_outputs(input string tag, input logic [W+1:0] e);
        check({tag, "_sum"},  32'(sum),  32'(e[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(e[W]));
        check({tag, "_ovf"},  32'(ovf),  32'(e[W+1]));
    endtask

    // Called at a negedge while idle; returns at the negedge after E_{W+1}.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input bit hold);
        logic [W+1:0] e;
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = ci;
        exp_q.push_back(model(x, y, ci));
        @(posedge clk);
        #1;
        if (hold) begin
            a   = 8'hAA;
            b   = 8'h55;
            cin = 1'b0;
        end else begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
        end
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("sum_hold", 32'(sum),  32'(prev[W-1:0]));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done",  32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_outputs("result", e);
            prev = e;
        end
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle",  32'(busy), 32'd0);
        check_outputs("result_hold", prev);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        prev  = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_outputs("rst", '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check_outputs("idle", '0);

        // Basic and carry-chain cases, back to back (E0 and E10).
        do_op(8'h35, 8'h4A, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held high through RUN+DONE; the second op is picked up from IDLE.
        do_op(8'h10, 8'h20, 1'b0, 1'b1);
        do_op(8'hAA, 8'h55, 1'b0, 1'b0);

        // Reset between edges 4 and 5 of an operation.
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check_outputs("midrst", '0);
        prev = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h0F, 8'h01, 1'b0, 1'b0);

        // Overflow corners.
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);

        // Random operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
